// File: rtl/traffic_timebase.sv
// rtl/traffic_timebase.sv - 0.1 s traffic-light timebase with cycle counter and dimming PWM
module traffic_timebase #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int MAX_COUNT = 99,
  parameter int PWM_DIV   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       hold,
  input  logic       sync_clr,
  output logic [6:0] ten_secs,
  output logic       pwm_12p5,
  output logic       pwm_25,
  output logic       tick,
  output logic       cycle_done
);

  localparam logic [23:0] PRESC_TERM = 24'(TICK_DIV - 1);
  localparam logic [6:0]  MAX_VAL    = 7'(MAX_COUNT);
  localparam logic [7:0]  PWM_TERM   = 8'(PWM_DIV - 1);

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } mode_t;

  mode_t       mode;
  logic [23:0] presc;
  logic        presc_term;
  logic [7:0]  pwm_div;
  logic [2:0]  slot;

  // Sequencing mode is decoded from the live inputs so leaving FROZEN costs no cycle
  always_comb begin
    mode = FROZEN;
    if (en && !hold) begin
      mode = RUN;
    end
  end

  assign presc_term = (presc == PRESC_TERM);

  // Prescaler, tick pulse and cycle position; sync_clr restarts everything and wins over en/hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= 24'd0;
      ten_secs   <= 7'd0;
      tick       <= 1'b0;
      cycle_done <= 1'b0;
    end else if (sync_clr) begin
      presc      <= 24'd0;
      ten_secs   <= 7'd0;
      tick       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      tick       <= en && presc_term;
      cycle_done <= 1'b0;
      if (en) begin
        presc <= presc_term ? 24'd0 : presc + 24'd1;
      end
      if (ten_secs > MAX_VAL) begin
        ten_secs <= 7'd0;
      end else if (mode == RUN && presc_term) begin
        if (ten_secs == MAX_VAL) begin
          ten_secs   <= 7'd0;
          cycle_done <= 1'b1;
        end else begin
          ten_secs <= ten_secs + 7'd1;
        end
      end
    end
  end

  // Free-running PWM slot sequencer; outputs show the slot just completed so slot 0 lands PWM_DIV clks after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_div  <= 8'd0;
      slot     <= 3'd0;
      pwm_12p5 <= 1'b0;
      pwm_25   <= 1'b0;
    end else if (pwm_div == PWM_TERM) begin
      pwm_div  <= 8'd0;
      slot     <= slot + 3'd1;
      pwm_12p5 <= (slot == 3'd0);
      pwm_25   <= (slot[2:1] == 2'b00);
    end else begin
      pwm_div <= pwm_div + 8'd1;
    end
  end

endmodule

// File: tb/tb_traffic_timebase.sv
// tb/tb_traffic_timebase.sv - directed self-checking bench for traffic_timebase
module tb_traffic_timebase;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       hold;
  logic       sync_clr;
  logic [6:0] ten_secs;
  logic       pwm_12p5;
  logic       pwm_25;
  logic       tick;
  logic       cycle_done;
  logic [6:0] ten_secs_b;
  logic       pwm_12p5_b;
  logic       pwm_25_b;
  logic       tick_b;
  logic       cycle_done_b;

  int checks;
  int failures;

  traffic_timebase #(.TICK_DIV(5), .MAX_COUNT(3), .PWM_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .sync_clr(sync_clr),
    .ten_secs(ten_secs), .pwm_12p5(pwm_12p5), .pwm_25(pwm_25),
    .tick(tick), .cycle_done(cycle_done)
  );

  traffic_timebase #(.TICK_DIV(5), .MAX_COUNT(3), .PWM_DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .sync_clr(sync_clr),
    .ten_secs(ten_secs_b), .pwm_12p5(pwm_12p5_b), .pwm_25(pwm_25_b),
    .tick(tick_b), .cycle_done(cycle_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input int t, input int ts, input int cd);
    chk({tag, "_tick"}, int'(tick), t);
    chk({tag, "_ten"}, int'(ten_secs), ts);
    chk({tag, "_cd"}, int'(cycle_done), cd);
  endtask

  int m;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    hold     = 1'b0;
    sync_clr = 1'b0;
    step();
    step();
    chk("rst_ten", int'(ten_secs), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_cd", int'(cycle_done), 0);
    chk("rst_pwm12", int'(pwm_12p5), 0);
    chk("rst_pwm25", int'(pwm_25), 0);

    // release with en=1; edge k counted from release
    rst_n = 1'b1;
    en    = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk_main("run", (k % 5 == 0) ? 1 : 0, (k / 5) % 4, (k == 20) ? 1 : 0);
      chk("run_pwm12", int'(pwm_12p5), ((k - 1) % 8 == 0) ? 1 : 0);
      chk("run_pwm25", int'(pwm_25), ((k - 1) % 8 < 2) ? 1 : 0);
      m = k / 3;
      chk("div3_pwm12", int'(pwm_12p5_b), (m > 0 && (m - 1) % 8 == 0) ? 1 : 0);
      chk("div3_pwm25", int'(pwm_25_b), (m > 0 && (m - 1) % 8 < 2) ? 1 : 0);
      chk("div3_tick", int'(tick_b), (k % 5 == 0) ? 1 : 0);
      chk("div3_ten", int'(ten_secs_b), (k / 5) % 4);
      chk("div3_cd", int'(cycle_done_b), (k == 20) ? 1 : 0);
    end

    // hold at ten_secs=2 for 12 clks: ticks continue, position frozen
    hold = 1'b1;
    for (int k = 31; k <= 42; k++) begin
      step();
      chk_main("hold", (k % 5 == 0) ? 1 : 0, 2, 0);
    end
    hold = 1'b0;
    step();
    chk_main("unhold43", 0, 2, 0);
    step();
    chk_main("unhold44", 0, 2, 0);
    step();
    chk_main("unhold45", 1, 3, 0);

    // en=0 mid-prescale (prescaler at 2) for 7 clks
    step();
    step();
    en = 1'b0;
    for (int k = 48; k <= 54; k++) begin
      step();
      chk_main("en_off", 0, 3, 0);
    end
    en = 1'b1;
    step();
    chk_main("reen55", 0, 3, 0);
    step();
    chk_main("reen56", 0, 3, 0);
    step();
    chk_main("reen57_wrap", 1, 0, 1);

    // run up to ten_secs=3 with prescaler at terminal count (edge 76)
    for (int k = 58; k <= 76; k++) begin
      step();
    end
    chk_main("pre_clr", 0, 3, 0);
    sync_clr = 1'b1;
    step();
    chk_main("sync_clr", 0, 0, 0);
    sync_clr = 1'b0;
    for (int k = 78; k <= 81; k++) begin
      step();
      chk_main("post_clr", 0, 0, 0);
    end
    step();
    chk_main("post_clr_tick", 1, 1, 0);

    // reach ten_secs=2, then pulse reset between edges
    for (int k = 83; k <= 89; k++) begin
      step();
    end
    chk_main("pre_rst", 0, 2, 0);
    chk("pre_rst_pwm12", int'(pwm_12p5), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ten", int'(ten_secs), 0);
    chk("async_pwm12", int'(pwm_12p5), 0);
    chk("async_pwm25", int'(pwm_25), 0);
    chk("async_tick", int'(tick), 0);
    chk("async_cd", int'(cycle_done), 0);
    step();
    chk("rst_hold_ten", int'(ten_secs), 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_main("restart", (k == 5) ? 1 : 0, (k == 5) ? 1 : 0, 0);
      chk("restart_pwm12", int'(pwm_12p5), (k == 1) ? 1 : 0);
      chk("restart_pwm25", int'(pwm_25), (k <= 2) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
